// File: rtl/arbiter_router_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : arbiter_router_pkg                                       |
// | Description : Shared items for the arbiter_router family: address      |
// |               width helper, {addr, payload} message sizing and the     |
// |               output-stage state encoding.                             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package arbiter_router_pkg;

  // Width of the source-index field; never narrower than one bit.
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Messages are laid out as {addr, payload}, address in the MSBs.
  function automatic int msg_width(input int nbits, input int ninputs);
    return nbits + addr_width(ninputs);
  endfunction

  // Single-entry output register occupancy.
  typedef enum logic [0:0] {
    OSTAGE_EMPTY = 1'b0,
    OSTAGE_FULL  = 1'b1
  } ostage_state_e;

endpackage
`default_nettype wire

// File: rtl/arbiter_router_rr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : arbiter_router_rr_arbiter_if                             |
// | Description : N input val/rdy streams plus one tagged output stream.   |
// |               master = traffic source/sink side, slave = the arbiter.  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface arbiter_router_rr_arbiter_if #(
  parameter int NBITS   = 32,
  parameter int NINPUTS = 4
);
  import arbiter_router_pkg::*;

  localparam int c_msg_bits = msg_width(NBITS, NINPUTS);

  logic [NINPUTS-1:0]            istream_val;
  logic [NINPUTS-1:0][NBITS-1:0] istream_msg;
  logic [NINPUTS-1:0]            istream_rdy;
  logic                          ostream_val;
  logic [c_msg_bits-1:0]         ostream_msg;
  logic                          ostream_rdy;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

endinterface
`default_nettype wire

// File: rtl/arbiter_router_rr_grant.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : arbiter_router_rr_grant                                  |
// | Description : Combinational round-robin pick. Scans requests starting  |
// |               at the priority pointer and returns a one-hot grant and  |
// |               the encoded winner index.                                |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module arbiter_router_rr_grant
  import arbiter_router_pkg::*;
#(
  parameter int NINPUTS = 4
) (
  input  wire logic [NINPUTS-1:0]                  i_req,
  input  wire logic [addr_width(NINPUTS)-1:0]      i_ptr,
  output      logic [NINPUTS-1:0]                  o_grant,
  output      logic [addr_width(NINPUTS)-1:0]      o_idx,
  output      logic                                o_any
);

  localparam int c_addr_bits = addr_width(NINPUTS);

  logic [c_addr_bits-1:0] w_cand;

  // First requester at or after ptr (modulo NINPUTS) wins.
  always_comb begin
    int v_sum;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    v_sum   = 0;
    for (int i = 0; i < NINPUTS; i++) begin
      v_sum = int'(i_ptr) + i;
      if (v_sum >= NINPUTS) v_sum = v_sum - NINPUTS;
      w_cand = v_sum[c_addr_bits-1:0];
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbiter_router_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : arbiter_router_rr_arbiter                                |
// | Description : N-to-1 round-robin arbiter with a registered output      |
// |               stage. Winning payloads are tagged {src_index, payload}. |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module arbiter_router_rr_arbiter
  import arbiter_router_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int NINPUTS = 4
) (
  input wire logic                  clk,
  input wire logic                  reset,
  arbiter_router_rr_arbiter_if.slave bus
);

  localparam int                     c_addr_bits = addr_width(NINPUTS);
  localparam logic [c_addr_bits-1:0] c_last_idx  = c_addr_bits'(NINPUTS - 1);

  ostage_state_e                 r_state;
  ostage_state_e                 w_state_nxt;
  logic [NBITS+c_addr_bits-1:0]  r_msg;
  logic [NBITS+c_addr_bits-1:0]  w_msg_nxt;
  logic [c_addr_bits-1:0]        r_ptr;
  logic [c_addr_bits-1:0]        w_ptr_nxt;
  logic [c_addr_bits-1:0]        w_win_idx;
  logic [NINPUTS-1:0]            w_grant;
  logic                          w_any;
  logic                          w_can_accept;
  logic                          w_xfer;

  arbiter_router_rr_grant #(
    .NINPUTS (NINPUTS)
  ) u_grant (
    .i_req   (bus.istream_val),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

  // Output slot can take a new message if empty or draining this cycle.
  always_comb begin
    w_can_accept = (r_state == OSTAGE_EMPTY) || bus.ostream_rdy;
    w_xfer       = w_any && w_can_accept;
    w_state_nxt  = r_state;
    w_msg_nxt    = r_msg;
    w_ptr_nxt    = r_ptr;
    if (w_xfer) begin
      w_state_nxt = OSTAGE_FULL;
      w_msg_nxt   = {w_win_idx, bus.istream_msg[w_win_idx]};
      w_ptr_nxt   = (w_win_idx == c_last_idx) ? '0 : w_win_idx + 1'b1;
    end else if ((r_state == OSTAGE_FULL) && bus.ostream_rdy) begin
      w_state_nxt = OSTAGE_EMPTY;
    end
  end

  // Occupancy, held message and priority pointer; reset discards in-flight data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= OSTAGE_EMPTY;
      r_msg   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_msg   <= w_msg_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Only the winner sees rdy, and nobody does while reset is held.
  assign bus.istream_rdy = (reset && w_can_accept) ? w_grant : '0;
  assign bus.ostream_val = (r_state == OSTAGE_FULL);
  assign bus.ostream_msg = r_msg;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_router_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_arbiter_router_rr_arbiter                             |
// | Description : Directed self-checking bench for the round-robin arbiter.|
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_arbiter_router_rr_arbiter;

  localparam int NBITS   = 32;
  localparam int NINPUTS = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  arbiter_router_rr_arbiter_if #(.NBITS(NBITS), .NINPUTS(NINPUTS)) bus ();

  arbiter_router_rr_arbiter #(.NBITS(NBITS), .NINPUTS(NINPUTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] omsg(input int a, input logic [31:0] p);
    logic [1:0] a2;
    a2 = a[1:0];
    return {30'b0, a2, p};
  endfunction

  function automatic logic [31:0] pay(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    // Reset held with every input valid.
    reset = 1'b0;
    bus.istream_val = '1;
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < NINPUTS; i++) bus.istream_msg[i] = pay(i);
    repeat (3) tick();
    check("rst_rdy", 64'(bus.istream_rdy), 64'h0);
    check("rst_oval", 64'(bus.ostream_val), 64'h0);
    check("rst_omsg", 64'(bus.ostream_msg), 64'h0);
    bus.istream_val = '0;
    reset = 1'b1;
    tick();
    check("rst_ptr", 64'(dut.r_ptr), 64'h0);
    check("rst_oval_rel", 64'(bus.ostream_val), 64'h0);

    // Single input 2.
    bus.istream_val = 4'b0100;
    bus.istream_msg[2] = 32'hA5A5_A5A5;
    #1 check("single_rdy", 64'(bus.istream_rdy), 64'h4);
    tick();
    bus.istream_val = '0;
    check("single_oval", 64'(bus.ostream_val), 64'h1);
    check("single_omsg", 64'(bus.ostream_msg), 64'h2_A5A5_A5A5);
    check("single_ptr", 64'(dut.r_ptr), 64'h3);
    tick();
    check("single_drain", 64'(bus.ostream_val), 64'h0);

    // Bring ptr to 0 via input 3, then stream with all inputs valid.
    bus.istream_msg[2] = pay(2);
    bus.istream_val = 4'b1000;
    tick();
    check("pre_ptr", 64'(dut.r_ptr), 64'h0);
    bus.istream_val = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("stream_val%0d", k), 64'(bus.ostream_val), 64'h1);
      check($sformatf("stream_msg%0d", k), 64'(bus.ostream_msg), omsg(k % 4, pay(k % 4)));
    end

    // Backpressure with output full of input 3's message.
    bus.ostream_rdy = 1'b0;
    #1;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("bp_rdy%0d", j), 64'(bus.istream_rdy), 64'h0);
      check($sformatf("bp_msg%0d", j), 64'(bus.ostream_msg), omsg(3, pay(3)));
      check($sformatf("bp_val%0d", j), 64'(bus.ostream_val), 64'h1);
      check($sformatf("bp_ptr%0d", j), 64'(dut.r_ptr), 64'h0);
      tick();
    end
    bus.ostream_rdy = 1'b1;
    #1 check("bp_release_rdy", 64'(bus.istream_rdy), 64'h1);
    tick();
    check("bp_release_msg", 64'(bus.ostream_msg), omsg(0, pay(0)));
    check("bp_release_ptr", 64'(dut.r_ptr), 64'h1);

    // Wrap/skip: move ptr to 3, then only inputs 1 and 3 valid.
    bus.istream_val = 4'b0100;
    #1 check("skip_pre_rdy", 64'(bus.istream_rdy), 64'h4);
    tick();
    check("skip_ptr3", 64'(dut.r_ptr), 64'h3);
    bus.istream_val = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 3 : 1;
      #1 check($sformatf("skip_rdy%0d", k), 64'(bus.istream_rdy), 64'(1 << e));
      tick();
      check($sformatf("skip_msg%0d", k), 64'(bus.ostream_msg), omsg(e, pay(e)));
    end
    #1 check("skip_g3_rdy", 64'(bus.istream_rdy), 64'h8);
    tick();
    check("skip_ptr0", 64'(dut.r_ptr), 64'h0);
    bus.istream_val = 4'b1011;
    #1 check("in0_first_rdy", 64'(bus.istream_rdy), 64'h1);
    tick();
    check("in0_first_msg", 64'(bus.ostream_msg), omsg(0, pay(0)));
    check("in1_next_rdy", 64'(bus.istream_rdy), 64'h2);

    // Async reset while the output is full.
    bus.ostream_rdy = 1'b0;
    bus.istream_val = '0;
    tick();
    check("areset_pre_val", 64'(bus.ostream_val), 64'h1);
    bus.istream_val = '1;
    #2 reset = 1'b0;
    #1;
    check("areset_val", 64'(bus.ostream_val), 64'h0);
    check("areset_msg", 64'(bus.ostream_msg), 64'h0);
    check("areset_ptr", 64'(dut.r_ptr), 64'h0);
    check("areset_rdy", 64'(bus.istream_rdy), 64'h0);
    tick();
    bus.istream_val = 4'b0010;
    bus.ostream_rdy = 1'b1;
    reset = 1'b1;
    #1 check("post_rst_rdy", 64'(bus.istream_rdy), 64'h2);
    tick();
    check("post_rst_msg", 64'(bus.ostream_msg), omsg(1, pay(1)));
    check("post_rst_ptr", 64'(dut.r_ptr), 64'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
